// File: rtl/rv32i_types.sv
// Shared RV32I/RV64I load/store size codes and the memory access FSM state set.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    ERR
  } mau_state_e;

  // log2 of the access size in bytes; the sign bit of funct3 does not affect size
  function automatic logic [1:0] access_size_log2(input logic [2:0] f3);
    return f3[1:0];
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: stores shift data up onto the addressed lanes, loads shift
// the addressed lanes down to bit 0 and sign/zero-extend them according to funct3.
module mem_align import rv32i_types::*; #(
  parameter int DATA_W = 32
) (
  input  logic                          store,
  input  logic [2:0]                    funct3,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [DATA_W-1:0]             data,
  output logic [DATA_W-1:0]             result
);

  logic [DATA_W-1:0] lanes;

  // Keep the low `bits` bits and fill above them with the field's top bit or zeros.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input int unsigned       bits,
                                               input logic              sgn);
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] msb;
    mask = ~({DATA_W{1'b1}} << bits);
    msb  = mask & ~(mask >> 1);
    if (sgn && ((v & msb) != '0)) return v | ~mask;
    return v & mask;
  endfunction

  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and infers a latch.
    lanes  = data >> {offset, 3'b000};
    result = lanes;
    if (store) begin
      result = data << {offset, 3'b000};
    end else begin
      case (funct3_e'(funct3))
        F3_B:    result = extend(lanes, 8, 1'b1);
        F3_BU:   result = extend(lanes, 8, 1'b0);
        F3_H:    result = extend(lanes, 16, 1'b1);
        F3_HU:   result = extend(lanes, 16, 1'b0);
        F3_W:    result = extend(lanes, 32, 1'b1);
        F3_WU:   result = extend(lanes, 32, 1'b0);
        default: result = lanes;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// EX/MEM pipeline latch plus load/store sequencer: one outstanding memory request,
// held stable until mem_resp, with misalignment detection and a response timeout.
module mem_access_unit import rv32i_types::*; #(
  parameter int DATA_W  = 32,
  parameter int NFWD    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load,
  input  logic                        flush,
  input  logic                        ex_valid,
  input  logic                        ex_read,
  input  logic                        ex_write,
  input  logic [DATA_W-1:0]           ex_addr,
  input  logic [DATA_W-1:0]           ex_wdata,
  input  logic [2:0]                  ex_funct3,
  input  logic [$clog2(NFWD+1)-1:0]   fwd_sel,
  input  logic [NFWD*DATA_W-1:0]      fwd_data,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [DATA_W/8-1:0]         mem_byte_enable,
  input  logic                        mem_resp,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [DATA_W-1:0]           load_data,
  output logic                        done,
  output logic                        stall,
  output logic                        misaligned,
  output logic                        timeout
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mau_state_e        state;
  logic              lat_valid, lat_read, lat_write, flush_pend;
  logic [DATA_W-1:0] lat_addr, lat_wdata;
  logic [2:0]        lat_funct3, req_funct3;
  logic [CW-1:0]     wait_cnt;
  logic [OW-1:0]     lat_off;
  logic [1:0]        lat_size;
  logic [3:0]        lat_nbytes;
  logic [NB-1:0]     lat_be;
  logic              lat_misal, take, start, busy;
  logic [DATA_W-1:0] st_src, st_lanes, ld_value;

  assign lat_off = lat_addr[OW-1:0];

  always_comb begin
    st_src = lat_wdata;
    for (int k = 0; k < NFWD; k++)
      if (int'(fwd_sel) == k + 1) st_src = fwd_data[k*DATA_W +: DATA_W];
    lat_size = access_size_log2(lat_funct3);
    if (DATA_W == 32 && lat_size == 2'd3) lat_size = 2'd2;
    lat_nbytes = 4'd1 << lat_size;
    lat_misal  = (lat_off & OW'(lat_nbytes - 4'd1)) != '0;
    lat_be     = NB'(((16'd1 << lat_nbytes) - 16'd1) << lat_off);
  end

  assign take       = (state == IDLE) && lat_valid && (lat_read || lat_write);
  assign start      = take && !lat_misal;
  assign busy       = (state == REQ) || (state == WAIT_RESP);
  assign stall      = busy && !mem_resp;
  assign misaligned = take && lat_misal;
  assign timeout    = (state == ERR);
  assign done       = (busy && mem_resp) || misaligned || timeout;

  mem_align #(.DATA_W(DATA_W)) u_store_align (
    .store  (1'b1),
    .funct3 (lat_funct3),
    .offset (lat_off),
    .data   (st_src),
    .result (st_lanes)
  );

  mem_align #(.DATA_W(DATA_W)) u_load_align (
    .store  (1'b0),
    .funct3 (req_funct3),
    .offset (mem_address[OW-1:0]),
    .data   (mem_rdata),
    .result (ld_value)
  );

  // NOTE: state is written with non-blocking assignments only, and the async reset branch clears every register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_valid  <= 1'b0;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      flush_pend <= 1'b0;
    end else begin
      // An instruction is consumed once the sequencer picks it up, so it never reissues.
      if (take) lat_valid <= 1'b0;
      if (stall) begin
        if (flush) flush_pend <= 1'b1;
      end else if (flush_pend || (load && flush)) begin
        lat_valid  <= 1'b0;
        flush_pend <= 1'b0;
      end else if (load) begin
        lat_valid  <= ex_valid;
        lat_read   <= ex_read;
        lat_write  <= ex_write;
        lat_addr   <= ex_addr;
        lat_wdata  <= ex_wdata;
        lat_funct3 <= ex_funct3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      req_funct3      <= '0;
      load_data       <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state           <= REQ;
          wait_cnt        <= '0;
          mem_read        <= lat_read;
          mem_write       <= lat_write;
          mem_address     <= lat_addr;
          mem_wdata       <= st_lanes;
          mem_byte_enable <= lat_be;
          req_funct3      <= lat_funct3;
        end
        REQ, WAIT_RESP: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) load_data <= ld_value;
          end else if (wait_cnt == CNT_LAST) begin
            state     <= ERR;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end else begin
            state    <= WAIT_RESP;
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ERR: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes expected outcomes from a
// byte-level reference model, a negedge monitor pops and compares on every done.
module tb_mem_access_unit;

  localparam int DATA_W  = 32;
  localparam int NFWD    = 2;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        load = 1'b0, flush = 1'b0;
  logic        ex_valid = 1'b0, ex_read = 1'b0, ex_write = 1'b0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [1:0]  fwd_sel = '0;
  logic [63:0] fwd_data = '0;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] load_data;
  logic        done, stall, misaligned, timeout;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DATA_W), .NFWD(NFWD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .flush(flush),
    .ex_valid(ex_valid), .ex_read(ex_read), .ex_write(ex_write),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_funct3(ex_funct3),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .load_data(load_data),
    .done(done), .stall(stall), .misaligned(misaligned), .timeout(timeout)
  );

  typedef struct {
    bit        misal;
    bit        tmo;
    bit        rd;
    bit        wr;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
    bit [31:0] ldata;
    int        reqs;
    int        stalls;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  int          checks = 0, errors = 0;
  int          req_cnt = 0, stall_cnt = 0;
  bit          ld_pend = 1'b0;
  bit [31:0]   ld_exp;
  bit [2:0]    ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: size in bytes, byte offset, lanes and extension from first principles.
  function automatic exp_t model(bit rd, bit wr, bit [2:0] f3, bit [31:0] addr,
                                 bit [31:0] src, bit [31:0] rdata, int lat);
    exp_t      e;
    int        size, off;
    bit [31:0] v;
    size    = (f3[1:0] == 2'd3) ? 4 : (1 << f3[1:0]);
    off     = int'(addr[1:0]);
    e.misal = (off % size) != 0;
    e.tmo   = !e.misal && (lat >= TIMEOUT);
    e.rd    = rd && !e.misal;
    e.wr    = wr && !e.misal;
    e.addr  = addr;
    e.be    = 4'(((1 << size) - 1) << off);
    e.wdata = src << (8 * off);
    v       = rdata >> (8 * off);
    case (size)
      1:       e.ldata = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2:       e.ldata = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: e.ldata = v;
    endcase
    e.reqs   = e.misal ? 0 : (e.tmo ? TIMEOUT : lat + 1);
    e.stalls = e.misal ? 0 : (e.tmo ? TIMEOUT : lat);
    return e;
  endfunction

  task automatic issue(bit v, bit rd, bit wr, bit [2:0] f3, bit [31:0] addr, bit fl,
                       int lat, bit [31:0] wd, bit [31:0] rdat, bit [1:0] fs);
    bit [63:0] fd;
    bit [31:0] src;
    fd  = {$urandom, $urandom};
    src = (fs == 2'd1) ? fd[31:0] : (fs == 2'd2) ? fd[63:32] : wd;
    @(posedge clk); #1;
    load = 1'b1; flush = fl; ex_valid = v; ex_read = rd; ex_write = wr;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;
    fwd_sel = fs; fwd_data = fd; mem_rdata = rdat;
    if (v && (rd || wr) && !fl) sb.push_back(model(rd, wr, f3, addr, src, rdat, lat));
    @(posedge clk); #1;
    load = 1'b0; flush = 1'b0; ex_valid = 1'($urandom); ex_addr = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ld_pend) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_outstanding", sb.size(), 0);
    sb.delete();
  endtask

  // Memory side: wait for a request, hold mem_resp low for lat cycles, then answer.
  task automatic serve(int lat);
    int n;
    n = 0;
    while (!(mem_read || mem_write) && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    if (mem_read || mem_write) begin
      for (int i = 0; i < lat && i < TIMEOUT + 2; i++) begin
        @(posedge clk); #1;
      end
      if (lat < TIMEOUT) begin
        mem_resp = 1'b1;
        @(posedge clk); #1;
        mem_resp = 1'b0;
      end
    end
    drain();
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      req_cnt   = 0;
      stall_cnt = 0;
      ld_pend   = 1'b0;
    end else begin
      if (ld_pend) begin
        check("load_data", load_data, ld_exp);
        ld_pend = 1'b0;
      end
      if (stall) stall_cnt++;
      if (mem_read || mem_write) begin
        req_cnt++;
        if (sb.size() == 0)
          check("spurious_request", {mem_read, mem_write}, 2'b00);
        else
          check("request_fields",
                {mem_read, mem_write, mem_address, mem_byte_enable, sb[0].wr ? mem_wdata : 32'h0},
                {sb[0].rd, sb[0].wr, sb[0].addr, sb[0].be, sb[0].wr ? sb[0].wdata : 32'h0});
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          got = sb.pop_front();
          check("done_flags", {misaligned, timeout, mem_resp}, {got.misal, got.tmo, !got.misal && !got.tmo});
          check("request_cycles", req_cnt, got.reqs);
          check("stall_cycles", stall_cnt, got.stalls);
          if (got.rd && !got.tmo) begin
            ld_pend = 1'b1;
            ld_exp  = got.ldata;
          end
        end
        req_cnt   = 0;
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit        rd, v, fl;
    bit [2:0]  f3;
    bit [31:0] a;
    int        lat;
    #3;
    check("reset_outputs",
          {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, load_data,
           done, stall, misaligned, timeout}, 106'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    issue(1, 0, 1, 3'b010, 32'h104, 0, 3, 32'hDEADBEEF, 32'h0, 2'd0);       serve(3);
    issue(1, 0, 1, 3'b000, 32'h103, 0, 0, 32'h000000AB, 32'h0, 2'd0);       serve(0);
    issue(1, 1, 0, 3'b001, 32'h102, 0, 1, 32'h0, 32'h80011234, 2'd0);       serve(1);
    issue(1, 1, 0, 3'b101, 32'h102, 0, 2, 32'h0, 32'h80015678, 2'd0);       serve(2);
    issue(1, 1, 0, 3'b010, 32'h101, 0, 0, 32'h0, 32'h0, 2'd0);              serve(0);
    issue(1, 1, 0, 3'b010, 32'h100, 0, TIMEOUT, 32'h0, 32'h0, 2'd0);        serve(TIMEOUT);
    issue(1, 0, 1, 3'b001, 32'h20A, 0, 1, 32'h0, 32'h0, 2'd2);              serve(1);
    issue(1, 1, 0, 3'b000, 32'h300, 1, 0, 32'h0, 32'h0, 2'd0);              serve(0);

    // Reset while the request is waiting for its response.
    issue(1, 1, 0, 3'b010, 32'h200, 0, TIMEOUT, 32'h0, 32'h12345678, 2'd0);
    for (int n = 0; n < 4 && !mem_read; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1 check("reset_mid_access", {mem_read, mem_write, done, stall}, 4'b0000);
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(1, 1, 0, 3'b010, 32'h204, 0, 2, 32'h0, 32'hCAFEF00D, 2'd0);       serve(2);

    for (int t = 0; t < 40; t++) begin
      rd  = 1'($urandom_range(0, 1));
      f3  = rd ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      v   = $urandom_range(0, 9) != 0;
      fl  = $urandom_range(0, 9) == 0;
      lat = $urandom_range(0, 5);
      issue(v, rd, !rd, f3, a, fl, lat, $urandom, $urandom, 2'($urandom_range(0, 2)));
      serve(lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter NFWD, default 2, number of store-data forwarding sources.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for mem_resp.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports load/flush  in  1 each  advance the EX/MEM latch / latch a bubble.
REQ-007 SHALL have ports ex_valid, ex_read, ex_write  in  1 each  instruction valid, is load, is store.
REQ-008 SHALL have ports ex_addr, ex_wdata  in  DATA_W each  effective address, store data.
REQ-009 SHALL have port ex_funct3  in  3  RV funct3 size/sign code.
REQ-010 SHALL have ports fwd_sel  in  $clog2(NFWD+1), fwd_data  in  NFWD*DATA_W  (0 = latched data, k = source k-1).
REQ-011 SHALL have ports mem_read, mem_write  out  1, mem_address, mem_wdata  out  DATA_W, mem_byte_enable  out  DATA_W/8.
REQ-012 SHALL have ports mem_resp  in  1, mem_rdata  in  DATA_W.
REQ-013 SHALL have outputs load_data  DATA_W, done  1, stall  1, misaligned  1, timeout  1.

Function
REQ-014 The latch SHALL capture ex_* on clk when load=1 and stall=0; flush=1 with load=1 SHALL latch valid=0; flush has priority over load.
REQ-015 Store data SHALL be taken from fwd_sel mux, shifted left by 8*addr[log2(DATA_W/8)-1:0] onto byte lanes.
REQ-016 Byte enable SHALL be 1, 3, or all-ones (word; doubleword when DATA_W=64 and funct3=011) shifted by the address offset, truncated to DATA_W/8 bits.
REQ-017 An access SHALL be misaligned when its address is not a multiple of its size; misaligned=1 for one cycle, no memory request is issued, done=1 that cycle.
REQ-018 FSM states IDLE, REQ, WAIT_RESP, ERR.
REQ-019 IDLE -> REQ when the latched instruction is valid, is a read or write, and is aligned; otherwise it remains in IDLE.
REQ-020 In REQ and WAIT_RESP, mem_read/mem_write SHALL be held high with constant address, data, and byte enable until mem_resp.
REQ-021 REQ -> WAIT_RESP the next cycle if no mem_resp; on mem_resp (in REQ or WAIT_RESP) the FSM SHALL go to IDLE, pulse done, and deassert request.
REQ-022 A wait counter SHALL reach TIMEOUT -> ERR; ERR SHALL drop the request, pulse timeout and done for one cycle, then return to IDLE.
REQ-023 stall SHALL be 1 whenever state is REQ or WAIT_RESP and mem_resp=0 (combinational on mem_resp; zero-wait response = no stall).
REQ-024 load_data SHALL be mem_rdata shifted right by the offset then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU), registered on mem_resp; held otherwise.
REQ-025 flush during REQ/WAIT_RESP SHALL NOT abort the outstanding access; it is applied after completion.

Reset
REQ-026 reset_n=0 SHALL immediately force state IDLE, latch valid=0, counter=0, all outputs 0, regardless of clk.
REQ-027 Reset mid-access SHALL drop mem_read/mem_write asynchronously; no done pulse is generated.

Structure
REQ-028 The funct3 size/sign codes and the FSM state enum SHALL live in rv32i_types; the width parameters SHALL remain local.
REQ-029 Lane alignment and extension SHALL be a combinational sub-module mem_align, instantiated once for store data and once for load data.

Verification
REQ-030 SW addr 0x104 data 0xDEADBEEF, mem_resp after 3 cycles -> byte enable 4'b1111, stall for 3 cycles, done on the response cycle.
REQ-031 SB addr 0x103 data 0x000000AB -> byte enable 4'b1000, mem_wdata 0xAB000000, zero-wait resp, stall=0.
REQ-032 LH addr 0x102, mem_rdata 0x8001xxxx -> load_data 0xFFFF8001; LHU -> 0x00008001.
REQ-033 LW addr 0x101 -> misaligned=1, mem_read never asserted.
REQ-034 No mem_resp with TIMEOUT=4 -> timeout pulse after 4 wait cycles, request dropped, FSM back in IDLE.
REQ-035 reset_n low during WAIT_RESP -> mem_read=0 before the next clk edge; the first access after release proceeds normally.
